// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole CYC cycle.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SEL_W   = DATA_W / 8,
   parameter int unsigned TGD_W   = 1,
   parameter int unsigned TGC_W   = 1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   // master 0
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [SEL_W-1:0]  m0_sel_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   input  logic [TGD_W-1:0]  m0_tgd_i,
   input  logic [TGC_W-1:0]  m0_tgc_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic [TGD_W-1:0]  m0_tgd_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   output logic              m0_rty_o,
   // master 1
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [SEL_W-1:0]  m1_sel_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   input  logic [TGD_W-1:0]  m1_tgd_i,
   input  logic [TGC_W-1:0]  m1_tgc_i,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic [TGD_W-1:0]  m1_tgd_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   output logic              m1_rty_o,
   // slave
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [SEL_W-1:0]  s_sel_o,
   output logic [DATA_W-1:0] s_dat_o,
   output logic [TGD_W-1:0]  s_tgd_o,
   output logic [TGC_W-1:0]  s_tgc_o,
   input  logic [DATA_W-1:0] s_dat_i,
   input  logic [TGD_W-1:0]  s_tgd_i,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   input  logic              s_rty_i,
   // grant status {m1,m0}
   output logic [1:0]        gnt_o
);

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("wb_arbiter_2m: TIMEOUT must be >= 2");
   end

   // Encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      GNT0 = 2'b01,
      GNT1 = 2'b10
   } state_t;

   state_t state_q, state_d;
   logic   last_q, last_d;
   logic   stb_mux;
   logic   wd_fire;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               state_d = last_q ? GNT0 : GNT1;
            else if (m0_cyc_i)
               state_d = GNT0;
            else if (m1_cyc_i)
               state_d = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         GNT1: begin
            if (!m1_cyc_i) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address/data path defaults to m0 so only cyc/stb need gating when idle.
   always_comb begin
      s_cyc_o = 1'b0;
      stb_mux = 1'b0;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_sel_o = m0_sel_i;
      s_dat_o = m0_dat_i;
      s_tgd_o = m0_tgd_i;
      s_tgc_o = m0_tgc_i;
      if (state_q == GNT0) begin
         s_cyc_o = m0_cyc_i;
         stb_mux = m0_stb_i;
      end else if (state_q == GNT1) begin
         s_cyc_o = m1_cyc_i;
         stb_mux = m1_stb_i;
         s_we_o  = m1_we_i;
         s_adr_o = m1_adr_i;
         s_sel_o = m1_sel_i;
         s_dat_o = m1_dat_i;
         s_tgd_o = m1_tgd_i;
         s_tgc_o = m1_tgc_i;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_q;
   logic            term;
   logic            wd_run;

   assign term    = s_ack_i | s_err_i | s_rty_i;
   assign wd_run  = (state_q != IDLE) && stb_mux && !term;
   // A genuine termination in the expiry clock suppresses the synthetic err.
   assign wd_fire = wd_run && (wd_q == WD_LAST);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         wd_q <= '0;
      else if (!wd_run || wd_fire || (state_d != state_q))
         wd_q <= '0;
      else
         wd_q <= wd_q + 1'b1;
   end
`else
   assign wd_fire = 1'b0;
`endif

   assign s_stb_o  = stb_mux & ~wd_fire;
   assign gnt_o    = state_q;

   assign m0_dat_o = s_dat_i;
   assign m0_tgd_o = s_tgd_i;
   assign m1_dat_o = s_dat_i;
   assign m1_tgd_o = s_tgd_i;

   assign m0_ack_o = (state_q == GNT0) & s_ack_i;
   assign m0_err_o = (state_q == GNT0) & (s_err_i | wd_fire);
   assign m0_rty_o = (state_q == GNT0) & s_rty_i;
   assign m1_ack_o = (state_q == GNT1) & s_ack_i;
   assign m1_err_o = (state_q == GNT1) & (s_err_i | wd_fire);
   assign m1_rty_o = (state_q == GNT1) & s_rty_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed self-checking bench for wb_arbiter_2m (TIMEOUT overridden to 8).
module tb_wb_arbiter_2m;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned SEL_W  = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
   logic [ADDR_W-1:0] m0_adr, m1_adr, s_adr;
   logic [SEL_W-1:0]  m0_sel, m1_sel, s_sel;
   logic [DATA_W-1:0] m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
   logic [0:0]        m0_tgd_w, m1_tgd_w, m0_tgd_r, m1_tgd_r, s_tgd_w, s_tgd_r;
   logic [0:0]        m0_tgc, m1_tgc, s_tgc;
   logic              m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
   logic              s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
   logic [1:0]        gnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   wb_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
                   .TGD_W(1), .TGC_W(1), .TIMEOUT(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
      .m0_sel_i(m0_sel), .m0_dat_i(m0_dat_w), .m0_tgd_i(m0_tgd_w), .m0_tgc_i(m0_tgc),
      .m0_dat_o(m0_dat_r), .m0_tgd_o(m0_tgd_r), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
      .m0_rty_o(m0_rty),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
      .m1_sel_i(m1_sel), .m1_dat_i(m1_dat_w), .m1_tgd_i(m1_tgd_w), .m1_tgc_i(m1_tgc),
      .m1_dat_o(m1_dat_r), .m1_tgd_o(m1_tgd_r), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
      .m1_rty_o(m1_rty),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr), .s_sel_o(s_sel),
      .s_dat_o(s_dat_w), .s_tgd_o(s_tgd_w), .s_tgc_o(s_tgc),
      .s_dat_i(s_dat_r), .s_tgd_i(s_tgd_r), .s_ack_i(s_ack), .s_err_i(s_err),
      .s_rty_i(s_rty),
      .gnt_o(gnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
      m0_tgd_w = '0; m0_tgc = '0;
      m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
      m1_tgd_w = '0; m1_tgc = '0;
      s_dat_r = '0; s_tgd_r = '0; s_ack = 0; s_err = 0; s_rty = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 0;
      repeat (2) tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      m0_cyc = 1; m0_stb = 1; s_ack = 1;
      repeat (2) @(posedge clk);
      settle();
      total_cnt++;
      if (gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", gnt); else pass_cnt++;
      total_cnt++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0)
         $display("FAIL reset_s_cyc_stb got=%b%b exp=00", s_cyc, s_stb); else pass_cnt++;
      total_cnt++;
      if (m0_ack !== 1'b0) $display("FAIL reset_m0_ack got=%b exp=0", m0_ack); else pass_cnt++;
      rst_n = 1; s_ack = 0;
      #1;
      total_cnt++;
      if (gnt !== 2'b00) $display("FAIL release_gnt_same got=%b exp=00", gnt); else pass_cnt++;
      settle();
      total_cnt++;
      if (gnt !== 2'b01 || s_cyc !== 1'b1)
         $display("FAIL release_gnt_next got=%b cyc=%b exp=01 cyc=1", gnt, s_cyc); else pass_cnt++;
      // async reset mid-transfer drops the bus without waiting for a clock
      #2 rst_n = 0;
      #1;
      total_cnt++;
      if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0)
         $display("FAIL async_reset got gnt=%b cyc=%b stb=%b exp 00/0/0", gnt, s_cyc, s_stb);
      else pass_cnt++;
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h100; m1_sel = 4'hF; m1_tgc = 1'b1;
      m0_adr = 32'h200; m0_sel = 4'h1;
      settle();
      total_cnt++;
      if (gnt !== 2'b00 || s_cyc !== 1'b0)
         $display("FAIL single_latency got gnt=%b cyc=%b exp 00/0", gnt, s_cyc); else pass_cnt++;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b10 || s_cyc !== 1'b1 || s_stb !== 1'b1)
         $display("FAIL single_gnt got gnt=%b cyc=%b stb=%b exp 10/1/1", gnt, s_cyc, s_stb);
      else pass_cnt++;
      total_cnt++;
      if (s_adr !== 32'h100 || s_sel !== 4'hF || s_tgc !== 1'b1 || s_we !== 1'b0)
         $display("FAIL single_mux got adr=%h sel=%h tgc=%b we=%b exp 100/f/1/0",
                  s_adr, s_sel, s_tgc, s_we);
      else pass_cnt++;
      total_cnt++;
      if (m1_ack !== 1'b0) $display("FAIL single_early_ack got=%b exp=0", m1_ack); else pass_cnt++;
      tick();
      tick();
      s_ack = 1; s_dat_r = 32'hDEADBEEF;
      settle();
      total_cnt++;
      if (m1_ack !== 1'b1 || m1_dat_r !== 32'hDEADBEEF)
         $display("FAIL single_ack got ack=%b dat=%h exp 1/deadbeef", m1_ack, m1_dat_r);
      else pass_cnt++;
      total_cnt++;
      if (m0_ack !== 1'b0 || m0_dat_r !== 32'hDEADBEEF)
         $display("FAIL single_m0_view got ack=%b dat=%h exp 0/deadbeef", m0_ack, m0_dat_r);
      else pass_cnt++;
      tick();
      m1_cyc = 0; m1_stb = 0; s_ack = 0;
      settle();
      total_cnt++;
      if (s_cyc !== 1'b0) $display("FAIL single_cyc_drop got=%b exp=0", s_cyc); else pass_cnt++;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b00) $display("FAIL single_idle got=%b exp=00", gnt); else pass_cnt++;
   endtask

   task automatic test_contention();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 32'hA0;
      m1_cyc = 1; m1_stb = 1; m1_adr = 32'hB0;
      s_ack = 1;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b01 || s_adr !== 32'hA0)
         $display("FAIL cont_first got gnt=%b adr=%h exp 01/a0", gnt, s_adr); else pass_cnt++;
      total_cnt++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0)
         $display("FAIL cont_acks got m0=%b m1=%b exp 1/0", m0_ack, m1_ack); else pass_cnt++;
      m0_cyc = 0; m0_stb = 0;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b00 || s_cyc !== 1'b0)
         $display("FAIL cont_gap got gnt=%b cyc=%b exp 00/0", gnt, s_cyc); else pass_cnt++;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b10 || s_adr !== 32'hB0 || m1_ack !== 1'b1 || m0_ack !== 1'b0)
         $display("FAIL cont_second got gnt=%b adr=%h m1=%b m0=%b exp 10/b0/1/0",
                  gnt, s_adr, m1_ack, m0_ack);
      else pass_cnt++;
   endtask

   task automatic test_fairness();
      logic [1:0] exp_gnt;
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1;
      for (int i = 0; i < 8; i++) begin
         exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
         tick(); settle();
         total_cnt++;
         if (gnt !== exp_gnt)
            $display("FAIL fair_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt); else pass_cnt++;
         total_cnt++;
         if ({m1_ack, m0_ack} !== exp_gnt)
            $display("FAIL fair_ack[%0d] got=%b exp=%b", i, {m1_ack, m0_ack}, exp_gnt);
         else pass_cnt++;
         if (exp_gnt[0]) m0_cyc = 0; else m1_cyc = 0;
         tick(); settle();
         total_cnt++;
         if (gnt !== 2'b00) $display("FAIL fair_gap[%0d] got=%b exp=00", i, gnt); else pass_cnt++;
         m0_cyc = 1; m1_cyc = 1;
      end
   endtask

   task automatic test_atomic();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; m1_adr = 32'hFFFF_0000;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b01) $display("FAIL atomic_start got=%b exp=01", gnt); else pass_cnt++;
      for (int k = 0; k < 4; k++) begin
         tick();
         s_ack = 0; m0_adr = 32'h1000 + 32'(4 * k);
         settle();
         total_cnt++;
         if (gnt !== 2'b01 || m1_ack !== 1'b0 || m0_ack !== 1'b0)
            $display("FAIL atomic_wait[%0d] got gnt=%b m0=%b m1=%b exp 01/0/0",
                     k, gnt, m0_ack, m1_ack);
         else pass_cnt++;
         tick();
         s_ack = 1; s_dat_r = 32'h1111_0000 + 32'(k);
         settle();
         total_cnt++;
         if (gnt !== 2'b01 || m0_ack !== 1'b1 || m1_ack !== 1'b0 ||
             m0_dat_r !== 32'h1111_0000 + 32'(k) || s_adr !== 32'h1000 + 32'(4 * k))
            $display("FAIL atomic_beat[%0d] got gnt=%b m0=%b m1=%b dat=%h adr=%h",
                     k, gnt, m0_ack, m1_ack, m0_dat_r, s_adr);
         else pass_cnt++;
      end
      tick();
      s_ack = 0; m0_cyc = 0; m0_stb = 0;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b00) $display("FAIL atomic_gap got=%b exp=00", gnt); else pass_cnt++;
      tick(); settle();
      total_cnt++;
      if (gnt !== 2'b10 || s_adr !== 32'hFFFF_0000)
         $display("FAIL atomic_handover got gnt=%b adr=%h exp 10/ffff0000", gnt, s_adr);
      else pass_cnt++;
   endtask

   task automatic test_timeout();
      int err_cnt;
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      tick(); settle();
`ifdef WB_ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         total_cnt++;
         if (m0_err !== 1'b0 || s_stb !== 1'b1)
            $display("FAIL wd_quiet[%0d] got err=%b stb=%b exp 0/1", i, m0_err, s_stb);
         else pass_cnt++;
         tick(); settle();
      end
      total_cnt++;
      if (m0_err !== 1'b1 || s_stb !== 1'b0 || m1_err !== 1'b0)
         $display("FAIL wd_fire got err=%b stb=%b m1err=%b exp 1/0/0", m0_err, s_stb, m1_err);
      else pass_cnt++;
      tick(); settle();
      total_cnt++;
      if (m0_err !== 1'b0 || s_stb !== 1'b1)
         $display("FAIL wd_after got err=%b stb=%b exp 0/1", m0_err, s_stb); else pass_cnt++;
`else
      err_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (m0_err !== 1'b0 || s_stb !== 1'b1) err_cnt++;
         tick(); settle();
      end
      total_cnt++;
      if (err_cnt !== 0 || gnt !== 2'b01)
         $display("FAIL no_wd got bad_clocks=%0d gnt=%b exp 0/01", err_cnt, gnt);
      else pass_cnt++;
`endif
      m0_cyc = 0; m0_stb = 0;
      tick();
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_atomic();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end
endmodule
